cms_trace_streamer: RTL and testbench
=====================================

Name: cms_trace_streamer

Overview:
Parametrised successor of the monitoring trace front end. It filters the retired-instruction stream by a runtime-selectable mode and accumulates NUM_EVENTS per-cycle core/tag-cache event counts across dropped instructions. Each accepted {events, pc, instr} packet goes into an internal first-word-fall-through FIFO that drives an AXI-Stream master. Packetisation uses an interval counter, a flush request and overflow accounting. It sits between the core trace/event ports and the DMA FIFO.

Parameters:
XLEN, 64, pc width
NUM_EVENTS, 4, number of event channels
EVT_WIDTH, 8, width of each event input and of each packed event accumulator
FIFO_DEPTH, 16, internal FIFO entries; power of two, >=2
DATA_WIDTH, NUM_EVENTS*EVT_WIDTH+XLEN+32, derived; tdata width

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
instr  in  32  retired instruction
pc  in  XLEN  pc of instr
pc_valid  in  1  instr/pc valid this cycle
events  in  NUM_EVENTS*EVT_WIDTH  per-cycle event increments; channel i at [i*EVT_WIDTH +: EVT_WIDTH]
filter_mode  in  2  0 pass all, 1 control-flow only, 2 JALR only, 3 drop all
flush  in  1  single-cycle request to close the current AXI packet
tlast_interval  in  32  beats per packet
M_AXIS_tvalid  out  1  stream valid
M_AXIS_tready  in  1  stream ready
M_AXIS_tdata  out  DATA_WIDTH  {event accumulators (ch NUM_EVENTS-1 at MSB), pc, instr}
M_AXIS_tlast  out  1  last beat of packet
overflow_count  out  32  packets lost to full FIFO
fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - FIFO empty.
  - All accumulators, beat counter, overflow_count and flush_pending = 0.
  - M_AXIS_tvalid=0, tlast=0, tdata=0, fifo_level=0.
  - Reset mid-transfer discards FIFO contents, with no handshake completion.
- Filter: opcode = instr[6:0].
  - Mode 1 keeps JAL 1101111, JALR 1100111 and BRANCH 1100011.
  - Mode 2 keeps only JALR.
  - Mode 0 keeps all; mode 3 keeps none.
  - keep = pc_valid & mode match. Combinational; filter_mode is sampled every cycle.
- Accumulators, per channel, unsigned, saturating at 2^EVT_WIDTH-1:
  - sum_i = sat(acc_i + events_i).
  - Write (keep & not full): the packet carries sum_i; acc_i <= 0.
  - Otherwise, including keep while full and pc_valid=0 cycles: acc_i <= sum_i.
- FIFO write/read:
  - Full is evaluated from start-of-cycle occupancy. A write while full is dropped even if a pop happens in the same cycle.
  - A drop increments overflow_count, which saturates at 0xFFFFFFFF.
  - A write at edge N gives M_AXIS_tvalid=1 after edge N (one-cycle latency) if the FIFO was empty.
  - tvalid = ~empty. tdata is the head entry.
  - While tvalid & ~tready, tdata/tlast are held stable.
  - Pop on tvalid & tready.
  - Simultaneous push and pop when not full leaves the level unchanged.
- tlast:
  - beat_cnt counts popped beats.
  - tlast = (beat_cnt == tlast_interval-1) | (flush_pending & fifo_level==1).
  - tlast_interval 0 or 1 means tlast on every beat.
  - beat_cnt resets to 0 on a beat popped with tlast=1; otherwise it increments on each pop.
  - tlast_interval changed mid-packet: compare against the new value. If beat_cnt already >= interval-1, the next beat carries tlast.
- flush:
  - Sets flush_pending if the FIFO is non-empty or a write occurs the same cycle; ignored otherwise.
  - flush_pending clears when a tlast beat pops.
  - A write arriving while flush_pending makes that later entry the tlast beat (level never reaches 1 before it pops).

Test Plan:
- Mode 0, tlast_interval=4, tready=1, 6 valid instrs with events=all 1 -> 6 beats, tlast on beat 4 only, each channel field=1, tvalid one cycle after first pc_valid.
- Mode 2, stream ADDI, JAL, JALR (pc=0x1000, instr=0x000080E7) with events ch0=3 each cycle -> single beat {ch0=9, ..., pc=0x1000, 0x000080E7}; accumulators 0 afterwards.
- tready=0, FIFO_DEPTH=16, 20 valid instrs in mode 0 -> fifo_level=16, overflow_count=4, tvalid held, tdata stable at first packet.
- EVT_WIDTH=8, events ch1=200 over 3 dropped cycles then keep -> ch1 field=255 (saturated).
- tlast_interval=8, 3 beats queued, flush pulse, tready=1 -> tlast on 3rd beat, beat_cnt back to 0, flush_pending cleared; flush with empty FIFO -> no effect.
- Assert rst for one cycle with 5 entries queued and tvalid high -> next cycle tvalid=0, fifo_level=0, overflow_count=0, accumulators 0.

Source files
------------

// File: rtl/cms_trace_streamer.sv
// Trace front end: filters retired instructions, folds per-cycle event counts into
// saturating accumulators and streams {events, pc, instr} packets over AXI-Stream.
module cms_trace_streamer #(
    parameter int XLEN       = 64,
    parameter int NUM_EVENTS = 4,
    parameter int EVT_WIDTH  = 8,
    parameter int FIFO_DEPTH = 16,
    localparam int DATA_WIDTH = NUM_EVENTS * EVT_WIDTH + XLEN + 32,
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [31:0]                      instr,
    input  logic [XLEN-1:0]                  pc,
    input  logic                             pc_valid,
    input  logic [NUM_EVENTS*EVT_WIDTH-1:0]  events,
    input  logic [1:0]                       filter_mode,
    input  logic                             flush,
    input  logic [31:0]                      tlast_interval,
    output logic                             M_AXIS_tvalid,
    input  logic                             M_AXIS_tready,
    output logic [DATA_WIDTH-1:0]            M_AXIS_tdata,
    output logic                             M_AXIS_tlast,
    output logic [31:0]                      overflow_count,
    output logic [LVL_W-1:0]                 fifo_level
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int EVW   = NUM_EVENTS * EVT_WIDTH;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]      count_q, count_d;
    logic [EVW-1:0]        acc_q, acc_d;
    logic [31:0]           overflow_q, overflow_d;
    logic [31:0]           beat_cnt_q, beat_cnt_d;
    logic                  flush_pending_q, flush_pending_d;

    logic                  mode_match;
    logic                  keep;
    logic                  full;
    logic                  empty;
    logic                  push;
    logic                  drop;
    logic                  pop;
    logic                  interval_hit;
    logic                  tlast;
    logic [EVW-1:0]        sum_vec;
    logic [EVT_WIDTH:0]    ch_sum;
    logic [DATA_WIDTH-1:0] wr_data;

    always_comb begin
        mode_match = 1'b0;
        case (filter_mode)
            2'd0:    mode_match = 1'b1;
            2'd1:    mode_match = (instr[6:0] == OP_JAL) || (instr[6:0] == OP_JALR) ||
                                  (instr[6:0] == OP_BRANCH);
            2'd2:    mode_match = (instr[6:0] == OP_JALR);
            default: mode_match = 1'b0;
        endcase
        keep = pc_valid & mode_match;
    end

    // The extra carry bit of each channel sum selects the saturated value.
    always_comb begin
        sum_vec = '0;
        ch_sum  = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            ch_sum = {1'b0, acc_q[i*EVT_WIDTH +: EVT_WIDTH]} +
                     {1'b0, events[i*EVT_WIDTH +: EVT_WIDTH]};
            sum_vec[i*EVT_WIDTH +: EVT_WIDTH] = ch_sum[EVT_WIDTH] ? {EVT_WIDTH{1'b1}}
                                                                  : ch_sum[EVT_WIDTH-1:0];
        end
    end

    always_comb begin
        full    = (count_q == LVL_W'(FIFO_DEPTH));
        empty   = (count_q == '0);
        push    = keep & ~full;
        drop    = keep & full;
        pop     = ~empty & M_AXIS_tready;
        wr_data = {sum_vec, pc, instr};

        // Intervals of 0 and 1 both mean every beat closes a packet.
        if (tlast_interval <= 32'd1) begin
            interval_hit = 1'b1;
        end else begin
            interval_hit = (beat_cnt_q >= (tlast_interval - 32'd1));
        end
        tlast = ~empty & (interval_hit | (flush_pending_q & (count_q == LVL_W'(1))));
    end

    always_comb begin
        wr_ptr_d        = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d        = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d         = count_q + LVL_W'(push) - LVL_W'(pop);
        acc_d           = push ? '0 : sum_vec;
        overflow_d      = (drop && (overflow_q != 32'hFFFF_FFFF)) ? overflow_q + 32'd1
                                                                  : overflow_q;
        beat_cnt_d      = beat_cnt_q;
        flush_pending_d = flush_pending_q;
        if (pop) begin
            beat_cnt_d = tlast ? 32'd0 : beat_cnt_q + 32'd1;
        end
        if (flush && (!empty || push)) begin
            flush_pending_d = 1'b1;
        end else if (pop && tlast) begin
            flush_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q        <= '0;
            rd_ptr_q        <= '0;
            count_q         <= '0;
            acc_q           <= '0;
            overflow_q      <= '0;
            beat_cnt_q      <= '0;
            flush_pending_q <= 1'b0;
        end else begin
            wr_ptr_q        <= wr_ptr_d;
            rd_ptr_q        <= rd_ptr_d;
            count_q         <= count_d;
            acc_q           <= acc_d;
            overflow_q      <= overflow_d;
            beat_cnt_q      <= beat_cnt_d;
            flush_pending_q <= flush_pending_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    always_comb begin
        M_AXIS_tvalid  = ~empty;
        M_AXIS_tdata   = empty ? '0 : mem_q[rd_ptr_q];
        M_AXIS_tlast   = tlast;
        overflow_count = overflow_q;
        fifo_level     = count_q;
    end

endmodule

// File: tb/tb_cms_trace_streamer.sv
// Scoreboard bench for cms_trace_streamer: stimulus queues expected beats, a forked
// monitor pops and compares them on every handshake.
module tb_cms_trace_streamer;

    localparam int DW = 128;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [31:0]   instr = '0;
    logic [63:0]   pc = '0;
    logic          pc_valid = 1'b0;
    logic [31:0]   events = '0;
    logic [1:0]    filter_mode = 2'd0;
    logic          flush = 1'b0;
    logic [31:0]   tlast_interval = 32'd4;
    logic          M_AXIS_tvalid;
    logic          M_AXIS_tready = 1'b1;
    logic [DW-1:0] M_AXIS_tdata;
    logic          M_AXIS_tlast;
    logic [31:0]   overflow_count;
    logic [4:0]    fifo_level;

    beat_t sb[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    cms_trace_streamer dut (
        .clk            (clk),
        .rst            (rst),
        .instr          (instr),
        .pc             (pc),
        .pc_valid       (pc_valid),
        .events         (events),
        .filter_mode    (filter_mode),
        .flush          (flush),
        .tlast_interval (tlast_interval),
        .M_AXIS_tvalid  (M_AXIS_tvalid),
        .M_AXIS_tready  (M_AXIS_tready),
        .M_AXIS_tdata   (M_AXIS_tdata),
        .M_AXIS_tlast   (M_AXIS_tlast),
        .overflow_count (overflow_count),
        .fifo_level     (fifo_level)
    );

    function automatic logic [DW-1:0] mkData(input logic [7:0] e3, input logic [7:0] e2,
                                             input logic [7:0] e1, input logic [7:0] e0,
                                             input logic [63:0] p, input logic [31:0] i);
        return {e3, e2, e1, e0, p, i};
    endfunction

    task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                               input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [63:0] p, input logic [31:0] i,
                                 input logic [31:0] e);
        pc_valid = v;
        pc       = p;
        instr    = i;
        events   = e;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 64'h0, 32'h0, 32'h0);
    endtask

    task automatic expectBeat(input logic [DW-1:0] d, input logic l);
        beat_t b;
        b.data = d;
        b.last = l;
        sb.push_back(b);
    endtask

    task automatic doReset();
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        sb.delete();
        checkOutput("reset_tvalid", M_AXIS_tvalid, 0);
        checkOutput("reset_tlast", M_AXIS_tlast, 0);
        checkOutput("reset_tdata", M_AXIS_tdata, 0);
        checkOutput("reset_level", fifo_level, 0);
        checkOutput("reset_overflow", overflow_count, 0);
    endtask

    task automatic waitDrain();
        int n;
        n        = 0;
        pc_valid = 1'b0;
        events   = '0;
        flush    = 1'b0;
        while ((sb.size() != 0 || M_AXIS_tvalid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_done", (sb.size() == 0 && !M_AXIS_tvalid), 1);
    endtask

    task automatic monitorLoop();
        beat_t exp;
        forever begin
            @(negedge clk);
            if (!rst && M_AXIS_tvalid && M_AXIS_tready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat actual=%h expected=none", M_AXIS_tdata);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("beat_data", M_AXIS_tdata, exp.data);
                    checkOutput("beat_last", M_AXIS_tlast, exp.last);
                end
            end
        end
    endtask

    initial begin
        fork
            monitorLoop();
        join_none

        // Mode 0, interval 4, six beats with every channel incremented once.
        filter_mode    = 2'd0;
        tlast_interval = 32'd4;
        M_AXIS_tready  = 1'b1;
        doReset();
        idle(1);
        for (int k = 0; k < 6; k++) begin
            expectBeat(mkData(8'd1, 8'd1, 8'd1, 8'd1, 64'h100 + 64'(4 * k), 32'h13), k == 3);
            if (k == 0) checkOutput("tvalid_before_first", M_AXIS_tvalid, 0);
            applyStimulus(1'b1, 64'h100 + 64'(4 * k), 32'h13, 32'h0101_0101);
            if (k == 0) checkOutput("tvalid_latency", M_AXIS_tvalid, 1);
        end
        waitDrain();

        // Mode 2 keeps only the JALR; dropped cycles fold their events into it.
        doReset();
        filter_mode    = 2'd2;
        tlast_interval = 32'd1;
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd9, 64'h1000, 32'h0000_80E7), 1'b1);
        applyStimulus(1'b1, 64'hF00, 32'h0000_0013, 32'h3);
        applyStimulus(1'b1, 64'hF04, 32'h0000_006F, 32'h3);
        applyStimulus(1'b1, 64'h1000, 32'h0000_80E7, 32'h3);
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h2000, 32'h0000_80E7), 1'b1);
        applyStimulus(1'b1, 64'h2000, 32'h0000_80E7, 32'h0);
        waitDrain();

        // Mode 1 keeps JAL, BRANCH, JALR; mode 3 keeps nothing.
        filter_mode = 2'd1;
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h504, 32'h0000_006F), 1'b1);
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h508, 32'h0000_0063), 1'b1);
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h50C, 32'h0000_80E7), 1'b1);
        applyStimulus(1'b1, 64'h500, 32'h0000_0013, 32'h0);
        applyStimulus(1'b1, 64'h504, 32'h0000_006F, 32'h0);
        applyStimulus(1'b1, 64'h508, 32'h0000_0063, 32'h0);
        applyStimulus(1'b1, 64'h50C, 32'h0000_80E7, 32'h0);
        applyStimulus(1'b1, 64'h510, 32'h0000_3003, 32'h0);
        waitDrain();
        filter_mode = 2'd3;
        applyStimulus(1'b1, 64'h600, 32'h0000_80E7, 32'h0);
        idle(1);
        checkOutput("mode3_level", fifo_level, 0);

        // Backpressure: 20 writes into 16 entries, head held stable.
        doReset();
        filter_mode    = 2'd0;
        tlast_interval = 32'd4;
        M_AXIS_tready  = 1'b0;
        for (int k = 0; k < 20; k++) applyStimulus(1'b1, 64'h3000 + 64'(4 * k), 32'h13, 32'h0);
        idle(1);
        checkOutput("full_level", fifo_level, 16);
        checkOutput("full_overflow", overflow_count, 4);
        checkOutput("full_tvalid", M_AXIS_tvalid, 1);
        checkOutput("full_head", M_AXIS_tdata, mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h3000, 32'h13));
        idle(3);
        checkOutput("full_head_held", M_AXIS_tdata,
                    mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h3000, 32'h13));

        // Channel 1 saturates across dropped cycles.
        doReset();
        M_AXIS_tready  = 1'b1;
        tlast_interval = 32'd1;
        for (int k = 0; k < 3; k++) applyStimulus(1'b0, 64'h0, 32'h0, 32'h0000_C800);
        expectBeat(mkData(8'd0, 8'd0, 8'd255, 8'd0, 64'h700, 32'h13), 1'b1);
        applyStimulus(1'b1, 64'h700, 32'h13, 32'h0000_C800);
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h704, 32'h13), 1'b1);
        applyStimulus(1'b1, 64'h704, 32'h13, 32'h0);
        waitDrain();

        // Flush closes a short packet; a flush on an empty FIFO does nothing.
        doReset();
        tlast_interval = 32'd8;
        M_AXIS_tready  = 1'b0;
        for (int k = 0; k < 3; k++) begin
            expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h800 + 64'(4 * k), 32'h13), k == 2);
            applyStimulus(1'b1, 64'h800 + 64'(4 * k), 32'h13, 32'h0);
        end
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        checkOutput("flush_level", fifo_level, 3);
        M_AXIS_tready = 1'b1;
        waitDrain();
        flush = 1'b1;
        idle(1);
        flush = 1'b0;
        for (int k = 0; k < 8; k++) begin
            expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'h880 + 64'(4 * k), 32'h13), k == 7);
            applyStimulus(1'b1, 64'h880 + 64'(4 * k), 32'h13, 32'h0);
        end
        waitDrain();

        // Reset with entries queued and accumulators non-zero.
        doReset();
        M_AXIS_tready = 1'b0;
        for (int k = 0; k < 5; k++) applyStimulus(1'b1, 64'h900 + 64'(4 * k), 32'h13, 32'h0);
        applyStimulus(1'b0, 64'h0, 32'h0, 32'h0505_0505);
        applyStimulus(1'b0, 64'h0, 32'h0, 32'h0505_0505);
        checkOutput("prereset_level", fifo_level, 5);
        checkOutput("prereset_tvalid", M_AXIS_tvalid, 1);
        doReset();
        M_AXIS_tready = 1'b1;
        expectBeat(mkData(8'd0, 8'd0, 8'd0, 8'd0, 64'hA00, 32'h13), 1'b0);
        applyStimulus(1'b1, 64'hA00, 32'h13, 32'h0);
        waitDrain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
